yout_cmd_encoder: RTL



---
 rtl/yout_cmd_encoder_pkg.sv | 15 +
 rtl/yout_mirror_model.sv | 34 +++
 rtl/yout_cmd_encoder.sv | 93 +++++++++
 3 files changed

// File: rtl/yout_cmd_encoder_pkg.sv
// rtl/yout_cmd_encoder_pkg.sv - symbol encodings and encoder state enum shared with the decoder
package yout_cmd_encoder_pkg;

    localparam logic [1:0] SYM_IDLE = 2'd0;
    localparam logic [1:0] SYM_CLR  = 2'd1;
    localparam logic [1:0] SYM_TGL  = 2'd2;
    localparam logic [1:0] SYM_SET  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } enc_state_t;

endpackage

// File: rtl/yout_mirror_model.sv
// rtl/yout_mirror_model.sv - tracks the decoder's yout from the command symbols it completes
module yout_mirror_model
    import yout_cmd_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       update,
    input  logic [1:0] sym,
    output logic       y_model,
    output logic       y_known
);

    // update marks the edge on which the decoder sees the trailing idle symbol
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_model <= 1'b0;
            y_known <= 1'b0;
        end else if (update) begin
            case (sym)
                SYM_CLR: begin
                    y_model <= 1'b0;
                    y_known <= 1'b1;
                end
                SYM_SET: begin
                    y_model <= 1'b1;
                    y_known <= 1'b1;
                end
                SYM_TGL: y_model <= ~y_model;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/yout_cmd_encoder.sv
// rtl/yout_cmd_encoder.sv - serialises set/clear/toggle commands into decoder symbols with idle hold
module yout_cmd_encoder
    import yout_cmd_encoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic [1:0] x,
    output logic       busy,
    output logic       y_model,
    output logic       y_known,
    output logic       nop_err
);

    enc_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            x         <= SYM_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
            nop_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            nop_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        if (cmd_op != SYM_IDLE) begin
                            state     <= ST_SEND;
                            x         <= cmd_op;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                        end else begin
                            nop_err <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    state     <= ST_HOLD;
                    x         <= SYM_IDLE;
                    cnt       <= CNT_W'(HOLD_CYCLES - 1);
                    cmd_ready <= (HOLD_CYCLES == 1);
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        // last hold cycle doubles as the accept slot for back-to-back commands
                        if (accept && cmd_op != SYM_IDLE) begin
                            state     <= ST_SEND;
                            x         <= cmd_op;
                            cmd_ready <= 1'b0;
                        end else begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            nop_err   <= accept;
                        end
                    end else begin
                        cnt       <= cnt - 1'b1;
                        cmd_ready <= (cnt == CNT_W'(1));
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    x         <= SYM_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    yout_mirror_model u_mirror (
        .clk     (clk),
        .reset_n (reset_n),
        .update  (state == ST_SEND),
        .sym     (x),
        .y_model (y_model),
        .y_known (y_known)
    );

endmodule
